// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load/start/stop/enable/mode in, count and status flags out.
// The controller drives through master; the timer sits on slave.
interface countdown_timer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] count_in;
  logic             load;
  logic             start;
  logic             stop;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             expire;
  logic             done;

  modport master (
    output count_in, load, start, stop, en, mode,
    input  count_out, busy, expire, done
  );

  modport slave (
    input  count_in, load, start, stop, en, mode,
    output count_out, busy, expire, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter, one-shot or periodic; all outputs registered, one-cycle Expire pulse per expiry.
// No backpressure: commands act on the edge they are sampled, priority Reset > Stop > Load > Start > decrement.
module countdown_timer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  countdown_timer_if.slave tmr
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             mode_latched, mode_latched_nxt;
  logic             expire, expire_nxt;
  logic             done, done_nxt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      count        <= '0;
      reload       <= '0;
      mode_latched <= 1'b0;
      expire       <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      reload       <= reload_nxt;
      mode_latched <= mode_latched_nxt;
      expire       <= expire_nxt;
      done         <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    count_nxt        = count;
    reload_nxt       = reload;
    mode_latched_nxt = mode_latched;
    expire_nxt       = 1'b0;
    done_nxt         = done;

    if (tmr.stop && state == RUN) begin
      state_nxt = IDLE;
    end else if (tmr.load) begin
      reload_nxt = tmr.count_in;
      count_nxt  = tmr.count_in;
      done_nxt   = 1'b0;
      // Loading zero mid-run aborts quietly rather than expiring.
      if (state == RUN && tmr.count_in == '0) state_nxt = IDLE;
    end else if (tmr.start && state == IDLE && reload != '0) begin
      count_nxt        = reload;
      mode_latched_nxt = tmr.mode;
      done_nxt         = 1'b0;
      state_nxt        = RUN;
    end else if (state == RUN && tmr.en) begin
      if (count > WIDTH'(1)) begin
        count_nxt = count - WIDTH'(1);
      end else if (count == WIDTH'(1)) begin
        expire_nxt = 1'b1;
        if (mode_latched) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
    end
  end

  assign tmr.count_out = count;
  assign tmr.busy      = (state == RUN);
  assign tmr.expire    = expire;
  assign tmr.done      = done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer: expected {count, busy, expire, done} queued per driven cycle,
// observed outputs sampled 1ns after each edge, then drained and compared per scenario.
module tb_countdown_timer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  countdown_timer_if #(.WIDTH(16)) bus ();

  countdown_timer #(.WIDTH(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .tmr   (bus)
  );

  always #5 Clock = ~Clock;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [18:0] ex(input int c, input logic b, input logic x, input logic d);
    return {16'(c), b, x, d};
  endfunction

  // Drive one cycle of inputs, clock it, record the outputs after the edge.
  task automatic tick(input logic rs, input logic ld, input logic st, input logic sp,
                      input logic e, input logic md, input int cin);
    Reset        = rs;
    bus.load     = ld;
    bus.start    = st;
    bus.stop     = sp;
    bus.en       = e;
    bus.mode     = md;
    bus.count_in = 16'(cin);
    @(posedge Clock);
    #1;
    obs_q.push_back({bus.count_out, bus.busy, bus.expire, bus.done});
  endtask

  task automatic test_reset();
    logic [18:0] e, o;
    int idx = 0;
    exp_q.push_back(ex(0, 0, 0, 0)); tick(1, 1, 0, 0, 1, 0, 7);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(1, 0, 1, 0, 1, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic test_oneshot();
    logic [18:0] e, o;
    int idx = 0;
    exp_q.push_back(ex(5, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 5);
    exp_q.push_back(ex(5, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    for (int c = 4; c >= 1; c--) begin
      exp_q.push_back(ex(c, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    end
    exp_q.push_back(ex(0, 0, 1, 1)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 0, 1)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 0, 1)); tick(0, 0, 0, 0, 1, 0, 0);
    // Restart from the retained reload value clears Done.
    exp_q.push_back(ex(5, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(ex(5, 0, 0, 0)); tick(0, 0, 0, 1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL oneshot[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic test_periodic();
    logic [18:0] e, o;
    int idx = 0;
    exp_q.push_back(ex(3, 0, 0, 0)); tick(0, 1, 0, 0, 1, 1, 3);
    exp_q.push_back(ex(3, 1, 0, 0)); tick(0, 0, 1, 0, 1, 1, 0);
    // Mode input dropped to 0 while running must not matter.
    for (int i = 1; i <= 10; i++) begin
      if (i % 3 == 0) exp_q.push_back(ex(3, 1, 1, 0));
      else            exp_q.push_back(ex(3 - (i % 3), 1, 0, 0));
      tick(0, 0, 0, 0, 1, 0, 0);
    end
    exp_q.push_back(ex(2, 0, 0, 0)); tick(0, 0, 0, 1, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL periodic[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic test_en_toggle();
    logic [18:0] e, o;
    int idx = 0;
    int rem;
    exp_q.push_back(ex(4, 0, 0, 0)); tick(0, 1, 0, 0, 0, 0, 4);
    exp_q.push_back(ex(4, 1, 0, 0)); tick(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rem = 4 - (i + 1) / 2;
      if (rem == 0) exp_q.push_back(ex(0, 0, 1, 1));
      else          exp_q.push_back(ex(rem, 1, 0, 0));
      tick(0, 0, 0, 0, logic'(i % 2), 0, 0);
    end
    exp_q.push_back(ex(0, 0, 0, 1)); tick(0, 0, 0, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_toggle[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic test_stop();
    logic [18:0] e, o;
    int idx = 0;
    exp_q.push_back(ex(6, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 6);
    exp_q.push_back(ex(6, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    for (int c = 5; c >= 3; c--) begin
      exp_q.push_back(ex(c, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    end
    exp_q.push_back(ex(3, 0, 0, 0)); tick(0, 0, 0, 1, 1, 0, 0);
    exp_q.push_back(ex(3, 0, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(6, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(ex(5, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(5, 0, 0, 0)); tick(0, 0, 0, 1, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic test_load_cases();
    logic [18:0] e, o;
    int idx = 0;
    // Zero reload: Start ignored.
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    // Reload mid-run replaces the count with no decrement that edge.
    exp_q.push_back(ex(10, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 10);
    exp_q.push_back(ex(10, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    for (int c = 9; c >= 7; c--) begin
      exp_q.push_back(ex(c, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    end
    exp_q.push_back(ex(2, 1, 0, 0)); tick(0, 1, 0, 0, 1, 0, 2);
    exp_q.push_back(ex(1, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 1, 1)); tick(0, 0, 0, 0, 1, 0, 0);
    // Load zero while running aborts without Expire; Load clears Done.
    exp_q.push_back(ex(9, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 9);
    exp_q.push_back(ex(9, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(ex(8, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    // Stop on the would-be expiry edge suppresses Expire.
    exp_q.push_back(ex(2, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 2);
    exp_q.push_back(ex(2, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(ex(1, 1, 0, 0)); tick(0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex(1, 0, 0, 0)); tick(0, 0, 0, 1, 1, 0, 0);
    // N = 1 expires one enabled cycle after Start.
    exp_q.push_back(ex(1, 0, 0, 0)); tick(0, 1, 0, 0, 1, 0, 1);
    exp_q.push_back(ex(1, 1, 0, 0)); tick(0, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(ex(0, 0, 1, 1)); tick(0, 0, 0, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_cases[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] e, o;
    int idx = 0;
    exp_q.push_back(ex(5, 0, 0, 0)); tick(0, 1, 0, 0, 1, 1, 5);
    exp_q.push_back(ex(5, 1, 0, 0)); tick(0, 0, 1, 0, 1, 1, 0);
    for (int c = 4; c >= 2; c--) begin
      exp_q.push_back(ex(c, 1, 0, 0)); tick(0, 0, 0, 0, 1, 1, 0);
    end
    exp_q.push_back(ex(0, 0, 0, 0)); tick(1, 0, 0, 0, 1, 1, 0);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 0, 1, 0, 1, 1, 0);
    exp_q.push_back(ex(0, 0, 0, 0)); tick(0, 0, 0, 0, 1, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got cnt=%0d busy=%b exp=%b done=%b, want cnt=%0d busy=%b exp=%b done=%b",
                 idx, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
      end
      idx++;
    end
  endtask

  initial begin
    bus.count_in = '0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_en_toggle();
    test_stop();
    test_load_cases();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
